// File: rtl/instr_step_seq.sv
// Instruction-register and step-counter stage of the multicycle controller.
//
// Fetches an instruction word, latches its opcode fields (InsM = Ins[15:11],
// InsL = Ins[1:0]) and walks the step count Cnt through fetch, decode and
// execute. The downstream Buff_PC generator looks at Cnt/InsM/InsL and raises
// Buff_PC to close the instruction. Extras: fetch handshake, stall hold,
// illegal-opcode trap, step watchdog and a sticky HLT latch.
//
// Cnt  | meaning
// -----+---------------------------------------------------------------
// 0    | fetch: wait for Ins_Vld, latch fields (idle while Halted)
// 1    | decode: legality check on latched InsM/InsL
// 2..N | execute steps, N = MAX_STEP; reaching N without Buff_PC traps
//
// Ports:
//   clk        system clock, rising edge
//   Rst_n      asynchronous active-low reset
//   Ins        instruction word from memory
//   Ins_Vld    fetch acknowledge, Ins valid this cycle
//   Buff_PC    end-of-instruction from the Buff_PC generator
//   Stall      hold the current execute step
//   Fetch_Req  fetch request (registered)
//   Cnt        current step
//   InsM/InsL  latched opcode fields
//   Ins_Err    one-cycle illegal-opcode pulse
//   Step_Ovf   one-cycle watchdog pulse
//   Halted     sticky halt flag, cleared only by Rst_n
module instr_step_seq #(
  parameter int unsigned MAX_STEP = 7
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic [15:0] Ins,
  input  logic        Ins_Vld,
  input  logic        Buff_PC,
  input  logic        Stall,
  output logic        Fetch_Req,
  output logic [2:0]  Cnt,
  output logic [4:0]  InsM,
  output logic [1:0]  InsL,
  output logic        Ins_Err,
  output logic        Step_Ovf,
  output logic        Halted
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_STEP);

  logic [2:0] cnt_q, cnt_d;
  logic [4:0] insm_q, insm_d;
  logic [1:0] insl_q, insl_d;
  logic       ins_err_q, ins_err_d;
  logic       step_ovf_q, step_ovf_d;
  logic       halted_q, halted_d;
  logic       fetch_req_q, fetch_req_d;

  logic       op_legal;
  logic       op_hlt;

  // Only the opcode fields are decoded here; the middle bits go to the datapath.
  logic       unused_ins;
  assign unused_ins = ^Ins[10:2];

  always_comb begin
    op_legal = 1'b0;
    if (insm_q <= 5'b01000) op_legal = 1'b1;
    if (insm_q == 5'b01011) op_legal = 1'b1;
    if (insm_q >= 5'b10000 && insm_q <= 5'b10011) op_legal = 1'b1;
    if (insm_q == 5'b11000 || insm_q == 5'b11001) op_legal = 1'b1;
    // 11100 covers OutR (InsL 00) and HLT (InsL 01) only
    if (insm_q == 5'b11100 && insl_q[1] == 1'b0) op_legal = 1'b1;
  end

  assign op_hlt = (insm_q == 5'b11100) && (insl_q == 2'b01);

  always_comb begin
    cnt_d      = cnt_q;
    insm_d     = insm_q;
    insl_d     = insl_q;
    ins_err_d  = 1'b0;
    step_ovf_d = 1'b0;
    halted_d   = halted_q;

    if (halted_q) begin
      cnt_d = 3'd0;
    end else if (cnt_q == 3'd0) begin
      if (Ins_Vld) begin
        insm_d = Ins[15:11];
        insl_d = Ins[1:0];
        cnt_d  = 3'd1;
      end
    end else if (cnt_q == 3'd1 && !op_legal) begin
      // illegal opcode: trap and refetch, Buff_PC is not consumed
      ins_err_d = 1'b1;
      cnt_d     = 3'd0;
    end else if (Buff_PC) begin
      // end of instruction wins over Stall
      cnt_d = 3'd0;
      if (op_hlt) halted_d = 1'b1;
    end else if (Stall) begin
      cnt_d = cnt_q;
    end else if (cnt_q >= MAX_CNT) begin
      // watchdog: no Buff_PC by the last legal step
      step_ovf_d = 1'b1;
      cnt_d      = 3'd0;
    end else begin
      cnt_d = cnt_q + 3'd1;
    end

    fetch_req_d = (cnt_d == 3'd0) && !halted_d;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q       <= 3'd0;
      insm_q      <= 5'd0;
      insl_q      <= 2'd0;
      ins_err_q   <= 1'b0;
      step_ovf_q  <= 1'b0;
      halted_q    <= 1'b0;
      fetch_req_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      insm_q      <= insm_d;
      insl_q      <= insl_d;
      ins_err_q   <= ins_err_d;
      step_ovf_q  <= step_ovf_d;
      halted_q    <= halted_d;
      fetch_req_q <= fetch_req_d;
    end
  end

  assign Fetch_Req = fetch_req_q;
  assign Cnt       = cnt_q;
  assign InsM      = insm_q;
  assign InsL      = insl_q;
  assign Ins_Err   = ins_err_q;
  assign Step_Ovf  = step_ovf_q;
  assign Halted    = halted_q;

endmodule

// File: tb/tb_instr_step_seq.sv
module tb_instr_step_seq;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic [15:0] Ins;
  logic        Ins_Vld;
  logic        Buff_PC;
  logic        Stall;
  logic        Fetch_Req;
  logic [2:0]  Cnt;
  logic [4:0]  InsM;
  logic [1:0]  InsL;
  logic        Ins_Err;
  logic        Step_Ovf;
  logic        Halted;

  always #5 clk = ~clk;

  instr_step_seq #(.MAX_STEP(7)) dut (
    .clk       (clk),
    .Rst_n     (Rst_n),
    .Ins       (Ins),
    .Ins_Vld   (Ins_Vld),
    .Buff_PC   (Buff_PC),
    .Stall     (Stall),
    .Fetch_Req (Fetch_Req),
    .Cnt       (Cnt),
    .InsM      (InsM),
    .InsL      (InsL),
    .Ins_Err   (Ins_Err),
    .Step_Ovf  (Step_Ovf),
    .Halted    (Halted)
  );

  // observation word: {Cnt, InsM, InsL, Ins_Err, Step_Ovf, Halted, Fetch_Req}
  typedef logic [13:0] obs_t;

  typedef struct {
    logic [15:0] ins;
    logic        vld;
    logic        bpc;
    logic        stall;
    obs_t        exp;
  } vec_t;

  vec_t tbl[$];
  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t ex(input logic [2:0] c, input logic [4:0] m, input logic [1:0] l,
                              input logic e, input logic o, input logic h, input logic f);
    return {c, m, l, e, o, h, f};
  endfunction

  function automatic vec_t mk(input logic [15:0] ins, input logic vld, input logic bpc,
                              input logic stall, input obs_t e);
    vec_t v;
    v.ins = ins; v.vld = vld; v.bpc = bpc; v.stall = stall; v.exp = e;
    return v;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("cnt=%0d insm=%b insl=%b err=%b ovf=%b hlt=%b freq=%b",
                     o[13:11], o[10:6], o[5:4], o[3], o[2], o[1], o[0]);
  endfunction

  function automatic obs_t observe();
    return {Cnt, InsM, InsL, Ins_Err, Step_Ovf, Halted, Fetch_Req};
  endfunction

  task automatic check(input string name, input int id, input obs_t act, input obs_t req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %s, want %s", name, id, fmt(act), fmt(req));
    end
  endtask

  task automatic run_vec(input string name, input int id, input vec_t v);
    obs_t req;
    Ins     = v.ins;
    Ins_Vld = v.vld;
    Buff_PC = v.bpc;
    Stall   = v.stall;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    req = sb.pop_front();
    check(name, id, observe(), req);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    obs_t z;
    z = '0;
    Rst_n = 1'b0; Ins = '0; Ins_Vld = 1'b0; Buff_PC = 1'b0; Stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", 0, observe(), z);
    Rst_n = 1'b1;
    #1;
    check("rst_release", 0, observe(), z);

    // run an ADDI up to Cnt=3, then pull reset asynchronously mid-cycle
    run_vec("pre", 0, mk(16'h3800, 1, 0, 0, ex(3'd1, 5'b00111, 2'b00, 0, 0, 0, 0)));
    run_vec("pre", 1, mk(16'h0000, 0, 0, 0, ex(3'd2, 5'b00111, 2'b00, 0, 0, 0, 0)));
    run_vec("pre", 2, mk(16'h0000, 0, 0, 0, ex(3'd3, 5'b00111, 2'b00, 0, 0, 0, 0)));
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_rst", 0, observe(), z);
    @(posedge clk);
    #1;
    check("async_rst", 1, observe(), z);
    Rst_n = 1'b1;

    // fetch wait, then ADDI closed at Cnt=3
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd0, 5'b00000, 2'b00, 0, 0, 0, 1)));
    tbl.push_back(mk(16'h3800, 1, 0, 0, ex(3'd1, 5'b00111, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd2, 5'b00111, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd3, 5'b00111, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 1, 0, ex(3'd0, 5'b00111, 2'b00, 0, 0, 0, 1)));
    // ADD with stall at step 2, then stall and Buff_PC together
    tbl.push_back(mk(16'h0000, 1, 0, 0, ex(3'd1, 5'b00000, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd2, 5'b00000, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 1, ex(3'd2, 5'b00000, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 1, ex(3'd2, 5'b00000, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 1, 1, ex(3'd0, 5'b00000, 2'b00, 0, 0, 0, 1)));
    // illegal 01001, Buff_PC present at decode but not consumed
    tbl.push_back(mk(16'h4800, 1, 0, 0, ex(3'd1, 5'b01001, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 1, 0, ex(3'd0, 5'b01001, 2'b00, 1, 0, 0, 1)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd0, 5'b01001, 2'b00, 0, 0, 0, 1)));
    // illegal 11100 with InsL=10
    tbl.push_back(mk(16'hE002, 1, 0, 0, ex(3'd1, 5'b11100, 2'b10, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd0, 5'b11100, 2'b10, 1, 0, 0, 1)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd0, 5'b11100, 2'b10, 0, 0, 0, 1)));
    // illegal 10100, refetch straight away after the trap
    tbl.push_back(mk(16'hA000, 1, 0, 0, ex(3'd1, 5'b10100, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd0, 5'b10100, 2'b00, 1, 0, 0, 1)));
    // LDRri watchdog, with a stall hold at the last step
    tbl.push_back(mk(16'h1800, 1, 0, 0, ex(3'd1, 5'b00011, 2'b00, 0, 0, 0, 0)));
    for (int c = 2; c <= 7; c++)
      tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'(c), 5'b00011, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 1, ex(3'd7, 5'b00011, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd0, 5'b00011, 2'b00, 0, 1, 0, 1)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd0, 5'b00011, 2'b00, 0, 0, 0, 1)));
    // legal 01011 closed at decode: minimum two-cycle instruction
    tbl.push_back(mk(16'h5800, 1, 0, 0, ex(3'd1, 5'b01011, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 1, 0, ex(3'd0, 5'b01011, 2'b00, 0, 0, 0, 1)));
    // legal 11001
    tbl.push_back(mk(16'hC800, 1, 0, 0, ex(3'd1, 5'b11001, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd2, 5'b11001, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 1, 0, ex(3'd0, 5'b11001, 2'b00, 0, 0, 0, 1)));
    // OutR (11100/00) is legal and does not halt
    tbl.push_back(mk(16'hE000, 1, 0, 0, ex(3'd1, 5'b11100, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd2, 5'b11100, 2'b00, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 1, 0, ex(3'd0, 5'b11100, 2'b00, 0, 0, 0, 1)));
    // HLT closed at Cnt=2, then Ins_Vld pulses ignored
    tbl.push_back(mk(16'hE001, 1, 0, 0, ex(3'd1, 5'b11100, 2'b01, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 0, 0, ex(3'd2, 5'b11100, 2'b01, 0, 0, 0, 0)));
    tbl.push_back(mk(16'h0000, 0, 1, 0, ex(3'd0, 5'b11100, 2'b01, 0, 0, 1, 0)));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(16'h3800, 1, 0, 0, ex(3'd0, 5'b11100, 2'b01, 0, 0, 1, 0)));

    for (int i = 0; i < tbl.size(); i++)
      run_vec("tbl", i, tbl[i]);

    // only reset clears the halt latch
    #2;
    Rst_n = 1'b0;
    #1;
    check("halt_clear", 0, observe(), z);
    Rst_n = 1'b1;
    run_vec("post_halt", 0, mk(16'h0000, 0, 0, 0, ex(3'd0, 5'b00000, 2'b00, 0, 0, 0, 1)));
    run_vec("post_halt", 1, mk(16'h0800, 1, 0, 0, ex(3'd1, 5'b00001, 2'b00, 0, 0, 0, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_step_seq.md
Name: instr_step_seq

Overview:
- Instruction-register and step-counter stage of the multicycle RISC controller.
- Fetches the instruction word, latches the opcode fields and generates the step count. It drives Cnt/InsM/InsL into the Buff_PC generator directly downstream and consumes its Buff_PC to close each instruction.
- Adds fetch handshake, stall hold, illegal-opcode trap, step watchdog and HLT latch.

Parameters:
- MAX_STEP, 7, last legal Cnt value (1..7). Reaching it without Buff_PC is a watchdog fault.

Ports:
- clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Ins  in  16  instruction word from memory
- Ins_Vld  in  1  Ins valid this cycle (fetch acknowledge)
- Buff_PC  in  1  end-of-instruction from the Buff_PC generator, combinational on Cnt/InsM/InsL
- Stall  in  1  hold the current execute step
- Fetch_Req  out  1  fetch request
- Cnt  out  3  current step; 0 = fetch, 1 = decode, 2..MAX_STEP = execute
- InsM  out  5  latched Ins[15:11]
- InsL  out  2  latched Ins[1:0]
- Ins_Err  out  1  one-cycle illegal-opcode pulse
- Step_Ovf  out  1  one-cycle watchdog pulse
- Halted  out  1  sticky halt flag

Behaviour:
- Reset (Rst_n=0, asynchronous): Cnt=0, InsM=0, InsL=0, Ins_Err=0, Step_Ovf=0, Halted=0. Reset mid-instruction aborts it immediately. The first fetch starts on the first edge after release.
- All outputs are registered. Fetch_Req = (Cnt==0) && !Halted.
- FETCH (Cnt==0, !Halted):
  - Ins_Vld=1: latch InsM/InsL from Ins; Cnt becomes 1 on the same edge.
  - Ins_Vld=0: hold Cnt=0; InsM/InsL unchanged.
- DECODE (Cnt==1), legality check on the latched fields:
  - Legal InsM: 00000–01000, 01011, 10000–10011, 11000, 11001.
  - 11100 is legal only with InsL 00 (OutR) or 01 (HLT).
  - Illegal: Ins_Err=1 for exactly the next cycle; Cnt becomes 0; Buff_PC is ignored.
- Step rules, Cnt>=1, legal opcode, in priority order:
  - (a) Buff_PC=1: Cnt becomes 0 next edge, even if Stall=1.
  - (b) Stall=1: hold Cnt.
  - (c) Cnt==MAX_STEP: Step_Ovf=1 for one cycle; Cnt becomes 0.
  - (d) Otherwise: Cnt+1.
- Cnt never exceeds MAX_STEP and never wraps through 7→0 by increment.
- HLT (InsM=11100, InsL=01): on the edge where Buff_PC ends it, Halted is set and Cnt goes to 0. While halted: Cnt stays 0, Fetch_Req=0, Ins_Vld ignored. Only Rst_n clears Halted.
- Ins_Err and Step_Ovf are never high in the same cycle, and neither is high in the cycle after reset release.
- Latency: instruction accepted at edge N gives Cnt=1 at N. Minimum instruction length is fetch + decode = 2 cycles.

Test Plan:
- Reset: Rst_n=0 asserted mid-step at Cnt=3 → all outputs 0 immediately (asynchronous); after release Fetch_Req=1 and Cnt=0.
- Fetch wait: Ins_Vld held 0 for 3 cycles, then Ins=16'h3800 (ADDI) with Ins_Vld=1 → Cnt stays 0 for 3 cycles, then Cnt=1, InsM=5'b00111. Drive Buff_PC at Cnt=3 → Cnt sequence 1,2,3,0.
- Stall vs Buff_PC: ADD (16'h0000) with Stall=1 at Cnt=2 for 2 cycles → Cnt holds at 2. Then Stall=1 and Buff_PC=1 together → Cnt=0 next edge.
- Illegal opcode: Ins=16'h4800 (InsM=01001) → Ins_Err=1 for one cycle right after Cnt=1; Cnt returns to 0; Buff_PC not consumed. Repeat with InsM=11100, InsL=10 → same result.
- Watchdog: legal LDRri (16'h1800), Buff_PC held 0 → Cnt 1..7, then Step_Ovf=1 for one cycle and Cnt=0.
- Halt: Ins=16'hE001, Buff_PC at Cnt=2 → Halted=1, Fetch_Req=0; Ins_Vld pulses ignored for 5 cycles; Rst_n low clears Halted.
